// File: rtl/axi_pkg.sv
// AXI channel types shared by the write-path blocks.
// IdWidth is wide enough to carry a 2-bit port index on top of the requester id.
package axi_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

endpackage

// File: rtl/axi_wr_order_fifo.sv
// W-ordering FIFO: remembers which port owns each accepted AW, oldest first.
// Ports: clk_i/rst_ni, push_i/data_i, pop_i, data_o (head), full_o, empty_o.
module axi_wr_order_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [1<<PtrW];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: N requester ports onto one manager port.
// Ports: slv_aw/w/b per requester, mst_aw/w/b toward memory, clk_i, rst_ni.
module axi_wr_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned NoPorts   = 4,
    parameter int unsigned MaxWTrans = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  aw_chan_t            slv_aw_i       [NoPorts],
    input  logic [NoPorts-1:0]  slv_aw_valid_i,
    output logic [NoPorts-1:0]  slv_aw_ready_o,
    input  w_chan_t             slv_w_i        [NoPorts],
    input  logic [NoPorts-1:0]  slv_w_valid_i,
    output logic [NoPorts-1:0]  slv_w_ready_o,
    output b_chan_t             slv_b_o        [NoPorts],
    output logic [NoPorts-1:0]  slv_b_valid_o,
    input  logic [NoPorts-1:0]  slv_b_ready_i,
    output aw_chan_t            mst_aw_o,
    output logic                mst_aw_valid_o,
    input  logic                mst_aw_ready_i,
    output w_chan_t             mst_w_o,
    output logic                mst_w_valid_o,
    input  logic                mst_w_ready_i,
    input  b_chan_t             mst_b_i,
    input  logic                mst_b_valid_i,
    output logic                mst_b_ready_o
);

    localparam int unsigned PW = $clog2(NoPorts);

    logic [PW-1:0] last_q, last_d;
    logic [PW-1:0] lock_idx_q, lock_idx_d;
    logic          lock_q, lock_d;
    logic          active_q;
    logic [PW-1:0] sel_idx, cand, gnt_idx, head, b_port;
    logic          sel_vld, gnt_vld, aw_en, aw_hs, w_pop;
    logic          fifo_full, fifo_empty;

    // Round-robin search from last_q+1; highest k first so the nearest wins.
    always_comb begin
        sel_idx = last_q;
        sel_vld = 1'b0;
        cand    = '0;
        for (int k = NoPorts; k >= 1; k--) begin
            cand = PW'((int'(last_q) + k) % int'(NoPorts));
            if (slv_aw_valid_i[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Once offered to the manager, the grant is frozen until accepted.
    assign gnt_idx = lock_q ? lock_idx_q : sel_idx;
    assign gnt_vld = lock_q ? slv_aw_valid_i[gnt_idx] : sel_vld;

    // active_q keeps AW quiet through reset; FIFO full stalls AW.
    assign aw_en          = active_q & ~fifo_full;
    assign mst_aw_valid_o = aw_en & gnt_vld;
    assign aw_hs          = mst_aw_valid_o & mst_aw_ready_i;

    always_comb begin
        mst_aw_o = slv_aw_i[gnt_idx];
        mst_aw_o.id[IdWidth-1 -: PW] = gnt_idx;
        slv_aw_ready_o = '0;
        for (int i = 0; i < NoPorts; i++) begin
            if (gnt_idx == PW'(i)) slv_aw_ready_o[i] = aw_en & mst_aw_ready_i;
        end
    end

    always_comb begin
        last_d     = aw_hs ? gnt_idx : last_q;
        lock_d     = mst_aw_valid_o & ~mst_aw_ready_i;
        lock_idx_d = gnt_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= PW'(NoPorts - 1);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            active_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            active_q   <= 1'b1;
        end
    end

    axi_wr_order_fifo #(
        .Width (PW),
        .Depth (MaxWTrans)
    ) u_order (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (aw_hs),
        .data_i  (gnt_idx),
        .pop_i   (w_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // W follows AW order: only the port at the FIFO head is connected.
    always_comb begin
        mst_w_o       = slv_w_i[head];
        mst_w_valid_o = ~fifo_empty & slv_w_valid_i[head];
        slv_w_ready_o = '0;
        for (int i = 0; i < NoPorts; i++) begin
            if (head == PW'(i)) slv_w_ready_o[i] = ~fifo_empty & mst_w_ready_i;
        end
    end

    assign w_pop = mst_w_valid_o & mst_w_ready_i & mst_w_o.last;

    // B is steered by the port index carried in the top id bits.
    assign b_port = mst_b_i.id[IdWidth-1 -: PW];

    always_comb begin
        mst_b_ready_o = 1'b0;
        slv_b_valid_o = '0;
        for (int i = 0; i < NoPorts; i++) begin
            slv_b_o[i] = mst_b_i;
            slv_b_o[i].id[IdWidth-1 -: PW] = '0;
            if (b_port == PW'(i)) begin
                slv_b_valid_o[i] = mst_b_valid_i;
                mst_b_ready_o    = slv_b_ready_i[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter (NoPorts=4, MaxWTrans=4).
// AW/W expectations are queued by the tasks and checked by negedge monitors.
module tb_axi_wr_arbiter;
    import axi_pkg::*;

    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst_n;

    aw_chan_t       slv_aw [NP];
    logic [NP-1:0]  slv_aw_valid, slv_aw_ready;
    w_chan_t        slv_w [NP];
    logic [NP-1:0]  slv_w_valid, slv_w_ready;
    b_chan_t        slv_b [NP];
    logic [NP-1:0]  slv_b_valid, slv_b_ready;
    aw_chan_t       mst_aw;
    logic           mst_aw_valid, mst_aw_ready;
    w_chan_t        mst_w;
    logic           mst_w_valid, mst_w_ready;
    b_chan_t        mst_b;
    logic           mst_b_valid, mst_b_ready;

    int n_run = 0;
    int n_fail = 0;

    aw_chan_t exp_aw [$];
    w_chan_t  exp_w [$];
    aw_chan_t e_aw;
    w_chan_t  e_w;

    always #5 clk = ~clk;

    axi_wr_arbiter #(
        .NoPorts   (NP),
        .MaxWTrans (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .slv_aw_i       (slv_aw),
        .slv_aw_valid_i (slv_aw_valid),
        .slv_aw_ready_o (slv_aw_ready),
        .slv_w_i        (slv_w),
        .slv_w_valid_i  (slv_w_valid),
        .slv_w_ready_o  (slv_w_ready),
        .slv_b_o        (slv_b),
        .slv_b_valid_o  (slv_b_valid),
        .slv_b_ready_i  (slv_b_ready),
        .mst_aw_o       (mst_aw),
        .mst_aw_valid_o (mst_aw_valid),
        .mst_aw_ready_i (mst_aw_ready),
        .mst_w_o        (mst_w),
        .mst_w_valid_o  (mst_w_valid),
        .mst_w_ready_i  (mst_w_ready),
        .mst_b_i        (mst_b),
        .mst_b_valid_i  (mst_b_valid),
        .mst_b_ready_o  (mst_b_ready)
    );

    function automatic aw_chan_t mk_aw(input logic [3:0] id, input logic [31:0] addr,
                                       input logic [7:0] len);
        aw_chan_t a;
        a       = '0;
        a.id    = id;
        a.addr  = addr;
        a.len   = len;
        a.size  = 3'd2;
        a.burst = 2'b01;
        a.cache = 4'h3;
        a.atop  = 6'b010000;
        return a;
    endfunction

    function automatic aw_chan_t exp_of(input int p, input aw_chan_t a);
        aw_chan_t r;
        logic [1:0] pp;
        pp = 2'(p);
        r = a;
        r.id[3:2] = pp;
        return r;
    endfunction

    function automatic w_chan_t mk_w(input logic [31:0] data, input logic last);
        w_chan_t w;
        w      = '0;
        w.data = data;
        w.strb = '1;
        w.last = last;
        return w;
    endfunction

    // Scoreboard monitors: inputs only change at posedge+1, so a handshake
    // seen at negedge is the one that completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mst_aw_valid === 1'b1 && mst_aw_ready === 1'b1) begin
            n_run++;
            if (exp_aw.size() == 0) begin
                n_fail++;
                $display("FAIL aw_unexpected got id=%h addr=%h required none", mst_aw.id, mst_aw.addr);
            end else begin
                e_aw = exp_aw.pop_front();
                if (mst_aw !== e_aw) begin
                    n_fail++;
                    $display("FAIL aw_order got %h required %h", mst_aw, e_aw);
                end
            end
        end
        if (rst_n === 1'b1 && mst_w_valid === 1'b1 && mst_w_ready === 1'b1) begin
            n_run++;
            if (exp_w.size() == 0) begin
                n_fail++;
                $display("FAIL w_unexpected got data=%h last=%b required none", mst_w.data, mst_w.last);
            end else begin
                e_w = exp_w.pop_front();
                if (mst_w !== e_w) begin
                    n_fail++;
                    $display("FAIL w_order got %h required %h", mst_w, e_w);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int p = 0; p < NP; p++) begin
                if (slv_aw_valid[p]) begin
                    assert (slv_aw[p].id[3:2] == 2'b00)
                        else $error("illegal AW id %h on port %0d", slv_aw[p].id, p);
                    assert (!(slv_aw[p].atop[5:4] == 2'b10 || slv_aw[p].atop == 6'b110000 ||
                              slv_aw[p].atop == 6'b110001))
                        else $error("unsupported atop %b on port %0d", slv_aw[p].atop, p);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NP; p++) begin
            slv_aw[p] = '0;
            slv_w[p]  = '0;
        end
        slv_aw_valid = '0;
        slv_w_valid  = '0;
        slv_b_ready  = '0;
        mst_aw_ready = 1'b0;
        mst_w_ready  = 1'b0;
        mst_b        = '0;
        mst_b_valid  = 1'b0;
    endtask

    task automatic do_reset();
        n_run++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got aw=%0d w=%0d required 0 0", exp_aw.size(), exp_w.size());
        end
        exp_aw.delete();
        exp_w.delete();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_aw(input int p);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = slv_aw_ready[p];
        end
        if (!ok) begin
            n_run++;
            n_fail++;
            $display("FAIL aw_timeout port %0d got no ready required ready within 50 cycles", p);
        end
        tick();
    endtask

    task automatic wait_w(input int p);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = slv_w_ready[p];
        end
        if (!ok) begin
            n_run++;
            n_fail++;
            $display("FAIL w_timeout port %0d got no ready required ready within 50 cycles", p);
        end
        tick();
    endtask

    task automatic send_aw(input int p, input aw_chan_t a);
        exp_aw.push_back(exp_of(p, a));
        slv_aw[p] = a;
        slv_aw_valid[p] = 1'b1;
        wait_aw(p);
        slv_aw_valid[p] = 1'b0;
    endtask

    task automatic send_w(input int p, input w_chan_t w);
        exp_w.push_back(w);
        slv_w[p] = w;
        slv_w_valid[p] = 1'b1;
        wait_w(p);
        slv_w_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        slv_aw_valid = '1;
        slv_w_valid  = '1;
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        mst_b.id     = 4'h5;
        mst_b_valid  = 1'b1;
        repeat (2) tick();
        n_run++;
        if (mst_aw_valid !== 1'b0 || slv_aw_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_aw got valid=%b ready=%b required 0 0000", mst_aw_valid, slv_aw_ready);
        end
        n_run++;
        if (mst_w_valid !== 1'b0 || slv_w_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_w got valid=%b ready=%b required 0 0000", mst_w_valid, slv_w_ready);
        end
        n_run++;
        if (slv_b_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_b_comb got %b required 0010", slv_b_valid);
        end
        clear_inputs();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_w_lag();
        aw_chan_t a;
        w_chan_t  w;
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        a = mk_aw(4'h1, 32'h0000_0010, 8'd0);
        w = mk_w(32'hCAFE_0000, 1'b1);
        exp_aw.push_back(exp_of(0, a));
        exp_w.push_back(w);
        slv_aw[0] = a;
        slv_aw_valid[0] = 1'b1;
        slv_w[0] = w;
        slv_w_valid[0] = 1'b1;
        @(negedge clk);
        n_run++;
        if (mst_w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL w_lag got mst_w_valid=%b required 0", mst_w_valid);
        end
        tick();
        slv_aw_valid[0] = 1'b0;
        @(negedge clk);
        n_run++;
        if (mst_w_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL w_follow got mst_w_valid=%b required 1", mst_w_valid);
        end
        tick();
        slv_w_valid[0] = 1'b0;
    endtask

    task automatic test_rr();
        aw_chan_t a0, a1, a2, a3;
        mst_aw_ready = 1'b1;
        a0 = mk_aw(4'h0, 32'h0000_0100, 8'd0);
        a2 = mk_aw(4'h0, 32'h0000_0200, 8'd0);
        exp_aw.push_back(exp_of(0, a0));
        exp_aw.push_back(exp_of(2, a2));
        slv_aw[0] = a0;
        slv_aw[2] = a2;
        slv_aw_valid[0] = 1'b1;
        slv_aw_valid[2] = 1'b1;
        wait_aw(0);
        slv_aw_valid[0] = 1'b0;
        wait_aw(2);
        slv_aw_valid[2] = 1'b0;
        a1 = mk_aw(4'h3, 32'h0000_0110, 8'd0);
        a3 = mk_aw(4'h3, 32'h0000_0330, 8'd0);
        exp_aw.push_back(exp_of(3, a3));
        exp_aw.push_back(exp_of(1, a1));
        slv_aw[1] = a1;
        slv_aw[3] = a3;
        slv_aw_valid[1] = 1'b1;
        slv_aw_valid[3] = 1'b1;
        wait_aw(3);
        slv_aw_valid[3] = 1'b0;
        wait_aw(1);
        slv_aw_valid[1] = 1'b0;
    endtask

    task automatic test_hold();
        aw_chan_t a1, a3;
        mst_aw_ready = 1'b0;
        a1 = mk_aw(4'h0, 32'h0000_0111, 8'd2);
        a3 = mk_aw(4'h0, 32'h0000_0333, 8'd0);
        exp_aw.push_back(exp_of(1, a1));
        exp_aw.push_back(exp_of(3, a3));
        slv_aw[1] = a1;
        slv_aw_valid[1] = 1'b1;
        tick();
        slv_aw[3] = a3;
        slv_aw_valid[3] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_run++;
            if (mst_aw_valid !== 1'b1 || mst_aw !== exp_of(1, a1)) begin
                n_fail++;
                $display("FAIL aw_hold got v=%b %h required 1 %h", mst_aw_valid, mst_aw, exp_of(1, a1));
            end
            tick();
        end
        mst_aw_ready = 1'b1;
        wait_aw(1);
        slv_aw_valid[1] = 1'b0;
        wait_aw(3);
        slv_aw_valid[3] = 1'b0;
    endtask

    task automatic test_fifo_full();
        aw_chan_t a;
        w_chan_t  w;
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_aw(0, mk_aw(4'h2, 32'h0000_0500 + 32'(i), 8'd0));
        end
        a = mk_aw(4'h2, 32'h0000_0504, 8'd0);
        exp_aw.push_back(exp_of(0, a));
        slv_aw[0] = a;
        slv_aw_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_run++;
            if (mst_aw_valid !== 1'b0 || slv_aw_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL full_stall got v=%b r=%b required 0 0", mst_aw_valid, slv_aw_ready[0]);
            end
            tick();
        end
        w = mk_w(32'h5555_0000, 1'b1);
        exp_w.push_back(w);
        slv_w[0] = w;
        slv_w_valid[0] = 1'b1;
        @(negedge clk);
        n_run++;
        if (mst_aw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_same_pop got mst_aw_valid=%b required 0", mst_aw_valid);
        end
        tick();
        slv_w_valid[0] = 1'b0;
        @(negedge clk);
        n_run++;
        if (mst_aw_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_resume got mst_aw_valid=%b required 1", mst_aw_valid);
        end
        tick();
        slv_aw_valid[0] = 1'b0;
    endtask

    task automatic test_w_order();
        w_chan_t w1;
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        send_aw(3, mk_aw(4'h1, 32'h0000_0300, 8'd3));
        send_aw(1, mk_aw(4'h2, 32'h0000_0100, 8'd0));
        w1 = mk_w(32'hAAAA_0001, 1'b1);
        slv_w[1] = w1;
        slv_w_valid[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_run++;
            if (mst_w_valid !== 1'b0 || slv_w_ready[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL w_block got v=%b r=%b required 0 0", mst_w_valid, slv_w_ready[1]);
            end
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            send_w(3, mk_w(32'h0000_0030 + 32'(b), (b == 3)));
        end
        exp_w.push_back(w1);
        @(negedge clk);
        n_run++;
        if (slv_w_ready[1] !== 1'b1 || mst_w_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL w_next got r=%b v=%b required 1 1", slv_w_ready[1], mst_w_valid);
        end
        tick();
        slv_w_valid[1] = 1'b0;
    endtask

    task automatic test_b();
        mst_b       = '0;
        mst_b.id    = 4'h5;
        mst_b.resp  = 2'b10;
        mst_b_valid = 1'b1;
        slv_b_ready = 4'b0010;
        @(negedge clk);
        n_run++;
        if (slv_b_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL b_route got %b required 0010", slv_b_valid);
        end
        n_run++;
        if (slv_b[1].id !== 4'h1 || slv_b[1].resp !== 2'b10) begin
            n_fail++;
            $display("FAIL b_id got id=%h resp=%b required 1 10", slv_b[1].id, slv_b[1].resp);
        end
        n_run++;
        if (mst_b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_ready_hi got %b required 1", mst_b_ready);
        end
        tick();
        slv_b_ready = 4'b1101;
        @(negedge clk);
        n_run++;
        if (mst_b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b_ready_lo got %b required 0", mst_b_ready);
        end
        tick();
        mst_b.id    = 4'hE;
        mst_b.resp  = 2'b00;
        slv_b_ready = 4'b1000;
        @(negedge clk);
        n_run++;
        if (slv_b_valid !== 4'b1000 || slv_b[3].id !== 4'h2 || mst_b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_port3 got v=%b id=%h r=%b required 1000 2 1",
                     slv_b_valid, slv_b[3].id, mst_b_ready);
        end
        tick();
        mst_b_valid = 1'b0;
        slv_b_ready = '0;
    endtask

    task automatic test_reset_mid();
        aw_chan_t a0, a3;
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        send_aw(2, mk_aw(4'h0, 32'h0000_0200, 8'd3));
        send_aw(0, mk_aw(4'h0, 32'h0000_0040, 8'd1));
        send_w(2, mk_w(32'h0000_0020, 1'b0));
        slv_w[2] = mk_w(32'h0000_0021, 1'b0);
        slv_w_valid[2] = 1'b1;
        slv_aw[1] = mk_aw(4'h0, 32'h0000_0140, 8'd0);
        slv_aw_valid[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (mst_aw_valid !== 1'b0 || slv_aw_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst_aw got v=%b r=%b required 0 0000", mst_aw_valid, slv_aw_ready);
        end
        n_run++;
        if (mst_w_valid !== 1'b0 || slv_w_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst_w got v=%b r=%b required 0 0000", mst_w_valid, slv_w_ready);
        end
        slv_aw_valid = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_run++;
        if (mst_w_valid !== 1'b0 || slv_w_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst_empty got v=%b r=%b required 0 0000", mst_w_valid, slv_w_ready);
        end
        tick();
        slv_w_valid = '0;
        a0 = mk_aw(4'h1, 32'h0000_0a00, 8'd0);
        a3 = mk_aw(4'h1, 32'h0000_0a30, 8'd0);
        exp_aw.push_back(exp_of(0, a0));
        exp_aw.push_back(exp_of(3, a3));
        slv_aw[0] = a0;
        slv_aw[3] = a3;
        slv_aw_valid[0] = 1'b1;
        slv_aw_valid[3] = 1'b1;
        wait_aw(0);
        slv_aw_valid[0] = 1'b0;
        wait_aw(3);
        slv_aw_valid[3] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_w_lag();
        do_reset();
        test_rr();
        do_reset();
        test_hold();
        do_reset();
        test_fifo_full();
        do_reset();
        test_w_order();
        do_reset();
        test_b();
        do_reset();
        test_reset_mid();
        repeat (2) tick();
        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter NoPorts, default 4, number of requester (slave-side) ports, legal range 2..4.
REQ-002 SHALL have parameter MaxWTrans, default 4, depth of the W-ordering FIFO, power of two, 1..16.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports slv_aw_i, input, NoPorts x aw_chan_t; slv_aw_valid_i, input, NoPorts; slv_aw_ready_o, output, NoPorts.
REQ-006 SHALL have ports slv_w_i, input, NoPorts x w_chan_t; slv_w_valid_i, input, NoPorts; slv_w_ready_o, output, NoPorts.
REQ-007 SHALL have ports slv_b_o, output, NoPorts x b_chan_t; slv_b_valid_o, output, NoPorts; slv_b_ready_i, input, NoPorts.
REQ-008 SHALL have ports mst_aw_o/mst_aw_valid_o/mst_aw_ready_i, mst_w_o/mst_w_valid_o/mst_w_ready_i and mst_b_i/mst_b_valid_i/mst_b_ready_o, one channel each, same types as REQ-005..007.

Function
REQ-009 SHALL arbitrate AW among ports with slv_aw_valid_i set, round-robin, search starting at (last granted port + 1) mod NoPorts.
REQ-010 SHALL hold the granted port and mst_aw_o stable from first assertion of mst_aw_valid_o until the mst_aw handshake (no re-arbitration while valid and not ready).
REQ-011 SHALL forward AW combinationally (zero latency): mst_aw_valid_o = granted valid; slv_aw_ready_o[g] = mst_aw_ready_i and FIFO not full; all other slv_aw_ready_o low.
REQ-012 SHALL replace the top PW = clog2(NoPorts) bits of mst_aw_o.id with the granted port index; all other AW fields pass unchanged, including atop.
REQ-013 SHALL deassert mst_aw_valid_o while the W-ordering FIFO is full; simultaneous pop does not free the slot in the same cycle.
REQ-014 SHALL push the granted port index into the W-ordering FIFO on every mst_aw handshake.
REQ-015 SHALL connect W only for the port at the FIFO head: mst_w_o = slv_w_i[head], mst_w_valid_o = slv_w_valid_i[head], slv_w_ready_o[head] = mst_w_ready_i, others low.
REQ-016 SHALL forward no W while the FIFO is empty; a push reaches the head in the next cycle (W lags AW by at least one cycle).
REQ-017 SHALL pop the FIFO on a mst_w handshake with last set; the next beat then comes from the new head, no bubble required.
REQ-018 SHALL route B to port p = top PW bits of mst_b_i.id: slv_b_valid_o[p] = mst_b_valid_i, mst_b_ready_o = slv_b_ready_i[p], the id top PW bits cleared in slv_b_o[p], other slv_b_valid_o low.
REQ-019 SHALL treat a requester AW id with nonzero top PW bits as illegal (simulation assertion); behaviour undefined.
REQ-020 SHALL not support atomic operations with read response; the bench flags atop[5:4]==2'b10 or atop==6'b110000 or 6'b110001 by assertion.

Reset
REQ-021 SHALL, on rst_ni low, asynchronously clear FIFO pointers and count, set the last-granted pointer to NoPorts-1 and clear the grant lock.
REQ-022 SHALL drive all valid and ready outputs low during reset, except those driven only combinationally from inputs: slv_b_valid_o and mst_b_ready_o.
REQ-023 SHALL discard in-flight transactions on mid-operation reset; there is no recovery of outstanding W or B.

Structure
REQ-024 SHALL take aw_chan_t, w_chan_t, b_chan_t and IdWidth from axi_pkg; no new package types are needed.
REQ-025 SHALL implement the W-ordering FIFO as sub-module axi_wr_order_fifo (index width PW, depth MaxWTrans, full/empty flags, push/pop).

Verification
REQ-026 Ports 0 and 2 assert AW together, mst_aw_ready_i=1, after reset -> grant order 0, 2; mst ids 0x0, 0x8 for slave ids 0x0.
REQ-027 Port 1 AW held with mst_aw_ready_i=0 for 5 cycles while port 3 raises valid -> mst_aw_o stays port 1, unchanged, until handshake.
REQ-028 Four AWs (len=0) from port 0, no W sent, MaxWTrans=4 -> fifth AW stalls (mst_aw_valid_o=0) until one W last handshake, then resumes next cycle.
REQ-029 AW port 3 (len=3) then AW port 1 (len=0); port 1 W valid first -> port 1 W blocked until 4 port-3 beats complete, then forwarded.
REQ-030 mst_b_i.id=0x5 valid, NoPorts=4 -> slv_b_valid_o[1]=1, slv_b_o[1].id=0x1, mst_b_ready_o follows slv_b_ready_i[1].
REQ-031 rst_ni pulsed low mid-burst with 2 FIFO entries -> FIFO empty, all AW/W valid and ready outputs low, next grant starts at port 0.
